// File: rtl/line_clear_ctrl_pkg.sv
// line_clear_ctrl_pkg: shared playfield constants, controller state type and popcount helper
package line_clear_ctrl_pkg;
    localparam int PLAYFIELD_ROWS = 20;
    localparam int PF_ROW_W = $clog2(PLAYFIELD_ROWS);
    localparam int LINE_FLASH_FRAMES = 12;
    typedef logic [PF_ROW_W-1:0] row_idx_t;
    typedef enum logic [1:0] {IDLE, FLASH, COMPACT, DONE} line_clear_state_t;
    function automatic int unsigned countSetBits(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) n += 32'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/line_clear_ctrl_if.sv
// line_clear_ctrl_if: game-logic request, flash display and row-copy handshake bundle
interface line_clear_ctrl_if import line_clear_ctrl_pkg::*; #(
    parameter int ROWS = PLAYFIELD_ROWS
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int CNT_W = $clog2(ROWS + 1);
    logic             start;
    logic [ROWS-1:0]  full_rows;
    logic             frame_tick;
    logic             busy;
    logic [ROWS-1:0]  flash_rows;
    logic             copy_valid;
    logic [ROW_W-1:0] copy_src;
    logic [ROW_W-1:0] copy_dst;
    logic             copy_blank;
    logic             copy_ready;
    logic             done;
    logic [CNT_W-1:0] lines_cleared;
    modport master (
        input  start, full_rows, frame_tick, copy_ready,
        output busy, flash_rows, copy_valid, copy_src, copy_dst, copy_blank, done, lines_cleared
    );
    modport slave (
        output start, full_rows, frame_tick, copy_ready,
        input  busy, flash_rows, copy_valid, copy_src, copy_dst, copy_blank, done, lines_cleared
    );
endinterface

// File: rtl/line_clear_ctrl_next_row_finder.sv
// line_clear_ctrl_next_row_finder: highest unset mask bit strictly below limit_i
module line_clear_ctrl_next_row_finder import line_clear_ctrl_pkg::*; #(
    parameter int ROWS = PLAYFIELD_ROWS,
    localparam int ROW_W = $clog2(ROWS),
    localparam int CNT_W = $clog2(ROWS + 1)
) (
    input  logic [ROWS-1:0]  mask_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [ROW_W-1:0] row_o,
    output logic             found_o
);
    always_comb begin
        row_o = '0;
        found_o = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            if (CNT_W'(i) < limit_i && !mask_i[i]) begin
                row_o = ROW_W'(i);
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: flashes captured full rows, then compacts the playfield bottom-up via row copies
module line_clear_ctrl import line_clear_ctrl_pkg::*; #(
    parameter int ROWS = PLAYFIELD_ROWS,
    parameter int FLASH_FRAMES = LINE_FLASH_FRAMES
) (
    input  logic              clk,
    input  logic              rst,
    line_clear_ctrl_if.master bus
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int CNT_W = $clog2(ROWS + 1);
    localparam int FRM_W = $clog2(FLASH_FRAMES + 1);
    line_clear_state_t state_q, state_d;
    logic [ROWS-1:0]  mask_q, mask_d, flash_q, flash_d;
    logic [ROW_W-1:0] src_q, src_d, dst_q, dst_d, csrc_q, csrc_d, cdst_q, cdst_d;
    logic             src_ok_q, src_ok_d, cv_q, cv_d, cb_q, cb_d, busy_q, busy_d, done_q, done_d;
    logic [FRM_W-1:0] frames_q, frames_d;
    logic [CNT_W-1:0] lines_q, lines_d;
    logic [ROWS-1:0]  find_mask;
    logic [CNT_W-1:0] find_limit;
    logic [ROW_W-1:0] find_row;
    logic             find_ok, accept, step;

    assign accept = bus.start && !busy_q;
    assign step = !cv_q || bus.copy_ready;
    // one finder serves both the initial source search and every per-step advance
    assign find_mask = state_q == IDLE ? bus.full_rows : mask_q;
    assign find_limit = state_q == IDLE ? CNT_W'(ROWS) : CNT_W'(src_q);

    line_clear_ctrl_next_row_finder #(.ROWS(ROWS)) u_finder (
        .mask_i (find_mask),
        .limit_i(find_limit),
        .row_o  (find_row),
        .found_o(find_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            src_q    <= '0;
            src_ok_q <= 1'b0;
            dst_q    <= '0;
            frames_q <= '0;
            lines_q  <= '0;
            flash_q  <= '0;
            cv_q     <= 1'b0;
            cb_q     <= 1'b0;
            csrc_q   <= '0;
            cdst_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            src_q    <= src_d;
            src_ok_q <= src_ok_d;
            dst_q    <= dst_d;
            frames_q <= frames_d;
            lines_q  <= lines_d;
            flash_q  <= flash_d;
            cv_q     <= cv_d;
            cb_q     <= cb_d;
            csrc_q   <= csrc_d;
            cdst_q   <= cdst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        src_d    = src_q;
        src_ok_d = src_ok_q;
        dst_d    = dst_q;
        frames_d = frames_q;
        lines_d  = lines_q;
        case (state_q)
            IDLE: if (accept) begin
                mask_d   = bus.full_rows;
                lines_d  = CNT_W'(countSetBits(32'(bus.full_rows)));
                state_d  = |bus.full_rows ? FLASH : DONE;
                dst_d    = ROW_W'(ROWS - 1);
                src_d    = find_row;
                src_ok_d = find_ok;
                frames_d = '0;
            end
            FLASH: if (bus.frame_tick) begin
                frames_d = frames_q + 1'b1;
                state_d  = frames_q == FRM_W'(FLASH_FRAMES - 1) ? COMPACT : FLASH;
            end
            COMPACT: if (step) begin
                dst_d    = dst_q - 1'b1;
                src_d    = find_row;
                src_ok_d = src_ok_q && find_ok;
                state_d  = dst_q == '0 ? DONE : COMPACT;
            end
            default: state_d = IDLE;
        endcase
    end

    // registered outputs are computed from next state so the request tracks the step with no bubble
    always_comb begin
        done_d = state_q == DONE;
        busy_d = state_d != IDLE || done_d;
        flash_d = state_d == FLASH ? mask_d : '0;
        cv_d = state_d == COMPACT && (!src_ok_d || src_d != dst_d);
        cb_d = state_d == COMPACT && !src_ok_d;
        csrc_d = state_d == COMPACT ? src_d : '0;
        cdst_d = state_d == COMPACT ? dst_d : '0;
    end

    assign bus.busy          = busy_q;
    assign bus.flash_rows    = flash_q;
    assign bus.copy_valid    = cv_q;
    assign bus.copy_src      = csrc_q;
    assign bus.copy_dst      = cdst_q;
    assign bus.copy_blank    = cb_q;
    assign bus.done          = done_q;
    assign bus.lines_cleared = lines_q;
endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb_line_clear_ctrl: directed clears checked against a compaction-order model and literal timings
module tb_line_clear_ctrl;
    import line_clear_ctrl_pkg::*;
    localparam int ROWS = 20;
    localparam int FF = 2;
    typedef struct packed {logic blank; logic [4:0] src; logic [4:0] dst;} wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_clear_ctrl_if #(.ROWS(ROWS)) bus ();
    line_clear_ctrl #(.ROWS(ROWS), .FLASH_FRAMES(FF)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // model: surviving rows, bottom-up, fill destinations bottom-up; leftovers become blanks
    wr_t exp_q[$];
    logic [19:0] m_mask = '0;
    int m_lines = 0;
    logic m_flash = 1'b0;
    int m_epoch = 0;
    function automatic void build(input logic [19:0] mask);
        int keep[$];
        int s;
        keep = {};
        exp_q = {};
        for (int r = ROWS - 1; r >= 0; r--) if (!mask[r]) keep.push_back(r);
        for (int d = ROWS - 1; d >= 0; d--) begin
            if (keep.size() == 0) exp_q.push_back({1'b1, 5'd0, 5'(d)});
            else begin
                s = keep.pop_front();
                if (s != d) exp_q.push_back({1'b0, 5'(s), 5'(d)});
            end
        end
        m_mask = mask;
        m_lines = $countones(mask);
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int hs_idx = 0, seen_epoch = 0, done_cnt = 0, done_cyc = 0, first_cv_cyc = -1, last_hs_cyc = 0;
    logic prev_stall = 1'b0;
    logic [11:0] prev_req = '0;
    wr_t e;
    always @(negedge clk) begin
        if (seen_epoch != m_epoch) begin
            seen_epoch = m_epoch;
            hs_idx = 0;
            first_cv_cyc = -1;
        end
        if (rst) begin
            chk("reset_flash_rows", 32'(bus.flash_rows), 0);
            chk("reset_outputs", {bus.busy, bus.copy_valid, bus.copy_src, bus.copy_dst, bus.copy_blank, bus.done, bus.lines_cleared}, 0);
            prev_stall = 1'b0;
        end else begin
            chk("flash_rows", 32'(bus.flash_rows), m_flash ? 32'(m_mask) : 32'd0);
            if (bus.busy) chk("lines_cleared", 32'(bus.lines_cleared), m_lines);
            if (m_flash) chk("no_copy_in_flash", bus.copy_valid, 0);
            if (prev_stall) chk("stall_hold", {bus.copy_valid, bus.copy_blank, bus.copy_src, bus.copy_dst}, prev_req);
            if (bus.copy_valid) begin
                if (first_cv_cyc < 0) first_cv_cyc = cyc;
                if (hs_idx >= exp_q.size()) chk("unexpected_request", 1, 0);
                else begin
                    e = exp_q[hs_idx];
                    chk("copy_req", {bus.copy_blank, bus.copy_blank ? 5'd0 : bus.copy_src, bus.copy_dst},
                        {e.blank, e.blank ? 5'd0 : e.src, e.dst});
                end
                if (bus.copy_ready) begin
                    hs_idx++;
                    last_hs_cyc = cyc;
                end
            end
            prev_stall = bus.copy_valid && !bus.copy_ready;
            prev_req = {bus.copy_valid, bus.copy_blank, bus.copy_src, bus.copy_dst};
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic nxt(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    int s_cyc, t_cyc, d0;

    task automatic begin_op(input logic [19:0] mask, input logic tick_with_start);
        build(mask);
        m_epoch++;
        s_cyc = cyc;
        bus.start = 1'b1;
        bus.full_rows = mask;
        bus.frame_tick = tick_with_start;
        nxt();
        bus.start = 1'b0;
        bus.full_rows = '0;
        bus.frame_tick = 1'b0;
        m_flash = mask != 0;
    endtask

    task automatic flash_ticks();
        for (int k = 0; k < FF; k++) begin
            nxt(2);
            bus.frame_tick = 1'b1;
            t_cyc = cyc;
            nxt();
            bus.frame_tick = 1'b0;
            if (k == FF - 1) m_flash = 1'b0;
        end
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while (done_cnt == d0 && k < bound) begin
            nxt();
            k++;
        end
        chk("done_timeout", done_cnt != d0, 1);
    endtask

    task automatic run_clear(input logic [19:0] mask, input logic tick_with_start, input int stall_at, input int stall_len);
        d0 = done_cnt;
        bus.copy_ready = 1'b1;
        begin_op(mask, tick_with_start);
        flash_ticks();
        if (stall_len > 0) begin
            nxt(stall_at);
            bus.copy_ready = 1'b0;
            nxt(stall_len);
            bus.copy_ready = 1'b1;
        end
        wait_done(200);
        chk("busy_falls_after_done", bus.busy, 0);
        chk("done_count", done_cnt - d0, 1);
        chk("all_writes_done", hs_idx, exp_q.size());
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0;
        bus.full_rows = '0;
        bus.frame_tick = 1'b0;
        bus.copy_ready = 1'b0;
        nxt(3);
        rst = 1'b0;
        nxt(2);

        // single bottom clear; a tick coincident with start must not count
        run_clear(20'h80000, 1'b1, 0, 0);
        chk("t1_model_n", exp_q.size(), 20);
        chk("t1_model_first", exp_q[0], {1'b0, 5'd18, 5'd19});
        chk("t1_model_last", exp_q[19], {1'b1, 5'd0, 5'd0});
        chk("t1_lines", bus.lines_cleared, 1);
        chk("t1_first_cv", first_cv_cyc - t_cyc, 1);
        chk("t1_no_bubbles", last_hs_cyc - first_cv_cyc, ROWS - 1);
        chk("t1_done_lat", done_cyc - t_cyc, ROWS + 2);

        // tetris with 5-cycle backpressure mid-compaction
        run_clear(20'hF0000, 1'b0, 3, 5);
        chk("t2_model_first", exp_q[0], {1'b0, 5'd15, 5'd19});
        chk("t2_model_blank", exp_q[16], {1'b1, 5'd0, 5'd3});
        chk("t2_lines", bus.lines_cleared, 4);
        chk("t2_done_lat", done_cyc - t_cyc, ROWS + 2 + 5);

        // split mask rows 17 and 19
        run_clear(20'hA0000, 1'b0, 0, 0);
        chk("t3_model_second", exp_q[1], {1'b0, 5'd16, 5'd18});
        chk("t3_model_blank", exp_q[18], {1'b1, 5'd0, 5'd1});
        chk("t3_lines", bus.lines_cleared, 2);
        chk("t3_done_lat", done_cyc - t_cyc, ROWS + 2);

        // top row only: everything suppressed except one blank to row 0
        run_clear(20'h00001, 1'b0, 0, 0);
        chk("t4_model_n", exp_q.size(), 1);
        chk("t4_one_request", hs_idx, 1);
        chk("t4_blank_cycle", first_cv_cyc - t_cyc, ROWS);
        chk("t4_done_lat", done_cyc - t_cyc, ROWS + 2);

        // zero mask and busy guard
        d0 = done_cnt;
        begin_op(20'h00000, 1'b0);
        chk("t5_busy_rise", bus.busy, 1);
        bus.start = 1'b1;
        bus.full_rows = 20'h80000;
        nxt(2);
        bus.start = 1'b0;
        bus.full_rows = '0;
        nxt(5);
        chk("t5_done_lat", done_cyc - s_cyc, 2);
        chk("t5_done_count", done_cnt - d0, 1);
        chk("t5_no_copy", first_cv_cyc, -1);
        chk("t5_lines", bus.lines_cleared, 0);
        chk("t5_idle", bus.busy, 0);

        // reset mid-compaction
        d0 = done_cnt;
        bus.copy_ready = 1'b1;
        begin_op(20'h80000, 1'b0);
        flash_ticks();
        nxt(4);
        chk("t6_in_compact", bus.copy_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_valid", bus.copy_valid, 0);
        chk("t6_rst_fields", {bus.copy_src, bus.copy_dst, bus.copy_blank}, 0);
        chk("t6_rst_lines", bus.lines_cleared, 0);
        nxt(2);
        rst = 1'b0;
        exp_q = {};
        m_epoch++;
        nxt(10);
        chk("t6_no_done", done_cnt - d0, 0);
        run_clear(20'h80000, 1'b0, 0, 0);
        chk("t6_fresh_lines", bus.lines_cleared, 1);
        chk("t6_fresh_done_lat", done_cyc - t_cyc, ROWS + 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
